// File: rtl/irq_cond_pkg.sv
// Shared types and widths for the IRQ input conditioner.
// Debounce FSM enabled by defining IRQ_DEBOUNCE_EN.
package irq_cond_pkg;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int SCNT_W = 4;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } deb_state_e;

  typedef struct packed {
    logic intsrc;
    logic drop;
    logic busy;
  } ch_stat_t;

endpackage

// File: rtl/irq_cond_channel.sv
// One interrupt channel: 2-flop sync, edge qualification, pulse stretch, drop flag.
// IRQ_DEBOUNCE_EN selects the debounce FSM; otherwise a plain rising-edge detect.
module irq_cond_channel
  import irq_cond_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int PULSE_LEN  = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     irq_in,
  input  logic     drop_clr,
  output ch_stat_t stat
);

  // Out-of-range settings leave this marker block in the elaborated hierarchy.
  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_illegal_deb_cycles
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_illegal_pulse_len
  end

  logic [1:0]        sync_pipe;
  logic              sync_q;
  logic              evt;
  logic              deb_busy;
  logic [SCNT_W-1:0] scnt;
  logic              intsrc_q;
  logic              drop_q;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], irq_in};
  end
  assign sync_q = sync_pipe[1];

`ifdef IRQ_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  deb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A bounce during RISE/FALL restarts from the previous stable level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_LOW: if (sync_q) begin
        state_nxt = ST_RISE;
        cnt_nxt   = CNT_W'(1);
      end
      ST_RISE: begin
        if (!sync_q)               state_nxt = ST_LOW;
        else if (cnt == CNT_LAST)  state_nxt = ST_HIGH;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      ST_HIGH: if (!sync_q) begin
        state_nxt = ST_FALL;
        cnt_nxt   = CNT_W'(1);
      end
      ST_FALL: begin
        if (sync_q)                state_nxt = ST_HIGH;
        else if (cnt == CNT_LAST)  state_nxt = ST_LOW;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ST_LOW;
    endcase
  end

  always_comb begin
    evt      = (state == ST_RISE) && sync_q && (cnt == CNT_LAST);
    deb_busy = (state == ST_RISE) || (state == ST_FALL);
  end
`else
  logic sync_prev;

  always_ff @(posedge clk) begin
    if (rst) sync_prev <= 1'b0;
    else     sync_prev <= sync_q;
  end

  assign evt      = sync_q & ~sync_prev;
  assign deb_busy = 1'b0;
`endif

  // Stretch is not retriggered; an event landing mid-pulse is recorded as dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt     <= '0;
      intsrc_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (evt && scnt == '0) scnt <= SCNT_W'(PULSE_LEN);
      else if (scnt != '0)   scnt <= scnt - 1'b1;
      intsrc_q <= (scnt != '0);
      if (evt && scnt != '0) drop_q <= 1'b1;
      else if (drop_clr)     drop_q <= 1'b0;
    end
  end

  assign stat.intsrc = intsrc_q;
  assign stat.drop   = drop_q;
  assign stat.busy   = deb_busy;

endmodule

// File: rtl/irq_input_conditioner.sv
// Three independent interrupt input conditioners feeding the CP0 samplers.
// Optional debounce FSM enabled by defining IRQ_DEBOUNCE_EN.
module irq_input_conditioner
  import irq_cond_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int PULSE_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic [NUM_CH-1:0] drop_clr,
  output logic [NUM_CH-1:0] intsrc,
  output logic [NUM_CH-1:0] drop,
  output logic [NUM_CH-1:0] busy
);

  ch_stat_t stat [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    irq_cond_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .PULSE_LEN  (PULSE_LEN)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .irq_in   (irq_in[i]),
      .drop_clr (drop_clr[i]),
      .stat     (stat[i])
    );
    assign intsrc[i] = stat[i].intsrc;
    assign drop[i]   = stat[i].drop;
    assign busy[i]   = stat[i].busy;
  end

endmodule

// File: tb/tb_irq_input_conditioner.sv
// Directed bench: two instances (16/4 and 2/15); expectations follow IRQ_DEBOUNCE_EN.
module tb_irq_input_conditioner;

`ifdef IRQ_DEBOUNCE_EN
  localparam int DEB_ON = 1;
  localparam int LAT_A  = 16 + 2;
  localparam int LAT_B  = 2 + 2;
`else
  localparam int DEB_ON = 0;
  localparam int LAT_A  = 3;
  localparam int LAT_B  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] irq_a, clr_a, intsrc_a, drop_a, busy_a;
  logic [2:0] irq_b, clr_b, intsrc_b, drop_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irq_input_conditioner #(.DEB_CYCLES(16), .PULSE_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .irq_in(irq_a), .drop_clr(clr_a),
    .intsrc(intsrc_a), .drop(drop_a), .busy(busy_a)
  );

  irq_input_conditioner #(.DEB_CYCLES(2), .PULSE_LEN(15)) dut_b (
    .clk(clk), .rst(rst), .irq_in(irq_b), .drop_clr(clr_b),
    .intsrc(intsrc_b), .drop(drop_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called right after driving at a negedge; sample j follows rising edge k+j-1.
  task automatic watch_a(input int ch, input int ncyc, output int first, output int hi,
                         output int busy_seen);
    first = -1; hi = 0; busy_seen = 0;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      if (intsrc_a[ch]) begin
        if (first < 0) first = j;
        hi++;
      end
      if (busy_a[ch]) busy_seen = 1;
    end
  endtask

  // Two 4-cycle pulses on dut_b ch2, 8 cycles apart; optional clear on the second event's edge.
  task automatic pair_b(input bit clr_at_evt, output int hi);
    hi = 0;
    for (int j = 0; j < 40; j++) begin
      irq_b[2] = (j < 4) || (j >= 8 && j < 12);
      clr_b[2] = clr_at_evt && (j == 8 + LAT_B - 1);
      @(negedge clk);
      if (intsrc_b[2]) hi++;
    end
    clr_b[2] = 1'b0;
  endtask

  initial begin
    int first, hi, bs;
    int hi3 [3];

    irq_a = '0; clr_a = '0; irq_b = '0; clr_b = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_intsrc_a", intsrc_a, 0);
    check("rst_drop_a", drop_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_intsrc_b", intsrc_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean rise on ch0 held 100 cycles
    irq_a[0] = 1'b1;
    watch_a(0, 100, first, hi, bs);
    check("t1_first", first, LAT_A + 1);
    check("t1_width", hi, 4);
    check("t1_busy_seen", bs, DEB_ON);
    check("t1_drop", drop_a, 0);
    irq_a[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("t1_idle_busy", busy_a, 0);

    // ch1 toggling every 3 cycles for 40 cycles
    hi = 0; bs = 0;
    for (int j = 0; j < 70; j++) begin
      irq_a[1] = (j < 40) && ((j / 3) % 2 == 0);
      @(negedge clk);
      if (intsrc_a[1]) hi++;
      if (busy_a[1]) bs = 1;
    end
    check("t2_high_cycles", hi, DEB_ON ? 0 : 28);
    check("t2_busy_seen", bs, DEB_ON);
    check("t2_end_busy", busy_a[1], 0);
    check("t2_drop", drop_a[1], 0);

    // Drop flag on dut_b ch2
    pair_b(1'b0, hi);
    check("t3_width", hi, 15);
    check("t3_drop_set", drop_b, 3'b100);
    clr_b[2] = 1'b1;
    @(negedge clk);
    clr_b[2] = 1'b0;
    check("t3_drop_clr", drop_b[2], 0);
    pair_b(1'b1, hi);
    check("t3_width2", hi, 15);
    check("t3_set_wins", drop_b[2], 1);
    clr_b[2] = 1'b1;
    @(negedge clk);
    clr_b[2] = 1'b0;
    check("t3_drop_clr2", drop_b[2], 0);

    // Reset during a RISE on ch0, input still high at release
    irq_a[0] = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_rst_intsrc", intsrc_a, 0);
    check("t4_rst_drop", drop_a, 0);
    check("t4_rst_busy", busy_a, 0);
    rst = 1'b0;
    watch_a(0, 60, first, hi, bs);
    check("t4_first", first, LAT_A + 1);
    check("t4_width", hi, 4);
    irq_a[0] = 1'b0;
    repeat (40) @(negedge clk);

    // All channels on the same edge
    hi3 = '{0, 0, 0};
    irq_a = 3'b111;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == LAT_A + 1) check("t5_same_cycle", intsrc_a, 3'b111);
      for (int c = 0; c < 3; c++) if (intsrc_a[c]) hi3[c]++;
    end
    check("t5_width0", hi3[0], 4);
    check("t5_width1", hi3[1], 4);
    check("t5_width2", hi3[2], 4);
    check("t5_drop", drop_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
